// File: rtl/video_pattern_gen_if.sv
// Stream bundle of the video pattern generator: start/stop/mode controls in,
// sync/valid/pixel data and run status out.
interface video_pattern_gen_if #(
    parameter int DATA_WIDTH = 8,
    parameter int CHANNELS   = 1
);
    logic                             vout_begin;
    logic                             vout_stop;
    logic [1:0]                       mode;
    logic [15:0]                      frame_num;
    logic                             vout_vsync;
    logic                             vout_hsync;
    logic                             vout_valid;
    logic [CHANNELS*DATA_WIDTH-1:0]   vout_dat;
    logic                             vout_busy;
    logic                             vout_done;
    logic [15:0]                      frame_cnt;
    logic [15:0]                      vout_xres;
    logic [15:0]                      vout_yres;

    modport master (
        input  vout_begin, vout_stop, mode, frame_num,
        output vout_vsync, vout_hsync, vout_valid, vout_dat,
               vout_busy, vout_done, frame_cnt, vout_xres, vout_yres
    );

    modport slave (
        output vout_begin, vout_stop, mode, frame_num,
        input  vout_vsync, vout_hsync, vout_valid, vout_dat,
               vout_busy, vout_done, frame_cnt, vout_xres, vout_yres
    );
endinterface

// File: rtl/video_pattern_gen.sv
// Timed video test-pattern source: counts frames of H_/V_ timing and emits
// gradient, colour-bar, checkerboard or moving-ramp pixels with registered outputs.
module video_pattern_gen #(
    parameter int DATA_WIDTH = 8,
    parameter int CHANNELS   = 1,
    parameter int H_SYNC     = 128,
    parameter int H_BACK     = 88,
    parameter int H_DISP     = 800,
    parameter int H_FRONT    = 40,
    parameter int H_TOTAL    = 1056,
    parameter int V_SYNC     = 4,
    parameter int V_BACK     = 23,
    parameter int V_DISP     = 600,
    parameter int V_FRONT    = 1,
    parameter int V_TOTAL    = 628,
    parameter int CHK_SHIFT  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    video_pattern_gen_if.master  vif
);

    localparam int PIX_W = CHANNELS * DATA_WIDTH;

    localparam logic [15:0] H_LAST   = 16'(H_TOTAL - 1);
    localparam logic [15:0] V_LAST   = 16'(V_TOTAL - 1);
    localparam logic [15:0] H_SYNC_E = 16'(H_SYNC);
    localparam logic [15:0] V_SYNC_E = 16'(V_SYNC);
    localparam logic [15:0] H_ACT_S  = 16'(H_SYNC + H_BACK);
    localparam logic [15:0] H_ACT_E  = 16'(H_SYNC + H_BACK + H_DISP);
    localparam logic [15:0] V_ACT_S  = 16'(V_SYNC + V_BACK);
    localparam logic [15:0] V_ACT_E  = 16'(V_SYNC + V_BACK + V_DISP);
    localparam logic [DATA_WIDTH-1:0] FS = '1;

    // Inconsistent timing sets would silently produce a wrong frame length.
    if (H_TOTAL != H_SYNC + H_BACK + H_DISP + H_FRONT) begin : g_bad_h_total
        $error("H_TOTAL does not equal the sum of the line timing parts");
    end
    if (V_TOTAL != V_SYNC + V_BACK + V_DISP + V_FRONT) begin : g_bad_v_total
        $error("V_TOTAL does not equal the sum of the frame timing parts");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic                    begin_d_r;
    logic                    go_s;
    logic                    run_s;
    logic                    eof_s;
    logic                    last_frame_s;
    logic [15:0]             h_cnt_r;
    logic [15:0]             v_cnt_r;
    logic [15:0]             frames_req_r;
    logic [15:0]             frame_cnt_r;
    logic [1:0]              mode_q_r;

    logic                    hsync_s;
    logic                    vsync_s;
    logic                    valid_s;
    logic [15:0]             x_s;
    logic [15:0]             y_s;
    logic [DATA_WIDTH-1:0]   x_dw_s;
    logic [DATA_WIDTH-1:0]   y_dw_s;
    logic [DATA_WIDTH-1:0]   f_dw_s;
    logic [2:0]              bar_idx_s;
    logic [2:0]              bar_code_s;
    logic [2:0]              bar_sel_s;
    logic                    chk_s;
    logic [DATA_WIDTH-1:0]   ch_s;
    logic [PIX_W-1:0]        pix_s;

    logic                    hsync_r;
    logic                    vsync_r;
    logic                    valid_r;
    logic [PIX_W-1:0]        dat_r;
    logic                    busy_r;
    logic                    done_r;

    assign go_s         = vif.vout_begin & ~begin_d_r;
    assign run_s        = (state_r == ST_RUN);
    assign eof_s        = run_s && (h_cnt_r == H_LAST) && (v_cnt_r == V_LAST);
    assign last_frame_s = (frames_req_r != 16'd0) && ((frame_cnt_r + 16'd1) == frames_req_r);

    // Previous level of the start request, for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            begin_d_r <= 1'b0;
        end else begin
            begin_d_r <= vif.vout_begin;
        end
    end

    // Run-control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode: a run ends only on an end-of-frame cycle.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (go_s) state_nxt_s = ST_RUN;
                else      state_nxt_s = ST_IDLE;
            end
            ST_RUN: begin
                if (eof_s && (last_frame_s || vif.vout_stop)) state_nxt_s = ST_DONE;
                else                                          state_nxt_s = ST_RUN;
            end
            ST_DONE: begin
                if (go_s) state_nxt_s = ST_RUN;
                else      state_nxt_s = ST_DONE;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Raster counters, frame bookkeeping and per-frame pattern select.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_r      <= 16'd0;
            v_cnt_r      <= 16'd0;
            frames_req_r <= 16'd0;
            frame_cnt_r  <= 16'd0;
            mode_q_r     <= 2'd0;
        end else if (go_s && !run_s) begin
            h_cnt_r      <= 16'd0;
            v_cnt_r      <= 16'd0;
            frames_req_r <= vif.frame_num;
            frame_cnt_r  <= 16'd0;
            mode_q_r     <= vif.mode;
        end else if (run_s) begin
            if (h_cnt_r == H_LAST) begin
                h_cnt_r <= 16'd0;
                if (v_cnt_r == V_LAST) v_cnt_r <= 16'd0;
                else                   v_cnt_r <= v_cnt_r + 16'd1;
            end else begin
                h_cnt_r <= h_cnt_r + 16'd1;
            end
            if (eof_s && (frame_cnt_r != 16'hFFFF)) frame_cnt_r <= frame_cnt_r + 16'd1;
            if ((h_cnt_r == 16'd0) && (v_cnt_r == 16'd0)) mode_q_r <= vif.mode;
        end else begin
            h_cnt_r <= 16'd0;
            v_cnt_r <= 16'd0;
        end
    end

    // Sync/valid decode and the pixel value for the current raster position.
    always_comb begin
        hsync_s = run_s && (h_cnt_r < H_SYNC_E);
        vsync_s = run_s && (v_cnt_r < V_SYNC_E);
        valid_s = run_s && (h_cnt_r >= H_ACT_S) && (h_cnt_r < H_ACT_E)
                        && (v_cnt_r >= V_ACT_S) && (v_cnt_r < V_ACT_E);
        x_s     = h_cnt_r - H_ACT_S;
        y_s     = v_cnt_r - V_ACT_S;
        x_dw_s  = DATA_WIDTH'(x_s);
        y_dw_s  = DATA_WIDTH'(y_s);
        f_dw_s  = DATA_WIDTH'(frame_cnt_r);
        chk_s   = x_s[CHK_SHIFT] ^ y_s[CHK_SHIFT];

        // Bar boundaries are elaboration-time constants, so no divider is built.
        bar_idx_s = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (x_s >= 16'(k * H_DISP / 8)) bar_idx_s = bar_idx_s + 3'd1;
            else                            bar_idx_s = bar_idx_s;
        end
        bar_code_s = 3'd7 - bar_idx_s;

        bar_sel_s = 3'd0;
        ch_s      = '0;
        pix_s     = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            bar_sel_s = bar_code_s >> (c % 3);
            case (mode_q_r)
                2'd0: begin
                    if (c == 0)      ch_s = x_dw_s;
                    else if (c == 1) ch_s = y_dw_s;
                    else             ch_s = x_dw_s + y_dw_s;
                end
                2'd1:    ch_s = bar_sel_s[0] ? FS : '0;
                2'd2:    ch_s = chk_s ? FS : '0;
                2'd3:    ch_s = x_dw_s + f_dw_s;
                default: ch_s = '0;
            endcase
            pix_s[c*DATA_WIDTH +: DATA_WIDTH] = ch_s;
        end
    end

    // Output registers; status follows the next state so busy/done align with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_r <= 1'b0;
            vsync_r <= 1'b0;
            valid_r <= 1'b0;
            dat_r   <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            hsync_r <= hsync_s;
            vsync_r <= vsync_s;
            valid_r <= valid_s;
            dat_r   <= valid_s ? pix_s : '0;
            busy_r  <= (state_nxt_s == ST_RUN);
            done_r  <= (state_nxt_s == ST_DONE);
        end
    end

    assign vif.vout_hsync = hsync_r;
    assign vif.vout_vsync = vsync_r;
    assign vif.vout_valid = valid_r;
    assign vif.vout_dat   = dat_r;
    assign vif.vout_busy  = busy_r;
    assign vif.vout_done  = done_r;
    assign vif.frame_cnt  = frame_cnt_r;
    assign vif.vout_xres  = 16'(H_DISP);
    assign vif.vout_yres  = 16'(V_DISP);

endmodule
